// File: rtl/des_subkey_gen_if.sv
// Handshake bundle between a DES round engine (master) and the subkey generator (slave).
interface des_subkey_gen_if;
   logic        start;
   logic        decrypt;
   logic [63:0] key_in;
   logic        sk_ready;
   logic [47:0] subkey;
   logic        sk_valid;
   logic [3:0]  round;
   logic        busy;
   logic        done;

   modport master (
      output start, decrypt, key_in, sk_ready,
      input  subkey, sk_valid, round, busy, done
   );

   modport slave (
      input  start, decrypt, key_in, sk_ready,
      output subkey, sk_valid, round, busy, done
   );
endinterface

// File: rtl/des_subkey_gen.sv
// DES key schedule: streams the 16 round subkeys of one key, K1..K16 for
// encryption or K16..K1 for decryption, over a valid/ready handshake.
module des_subkey_gen (
   input  logic            clk,
   input  logic            rst,
   des_subkey_gen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic [5:0] PC1 [56] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [5:0] PC2 [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   state_t      state, state_next;
   logic [27:0] c_q, d_q;
   logic [3:0]  round_q;
   logic        dir_q;
   logic        load, advance, two_step;
   logic [55:0] cd_load;

   // Tables use DES numbering (bit 1 = MSB of the vector).
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++)
         r[6'(55 - i)] = k[6'(64 - int'(PC1[6'(i)]))];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int j = 0; j < 48; j++)
         r[6'(47 - j)] = cd[6'(56 - int'(PC2[6'(j)]))];
      return r;
   endfunction

   function automatic logic ls_one(input logic [4:0] k);
      return (k == 5'd1) || (k == 5'd2) || (k == 5'd9) || (k == 5'd16);
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      load         = 1'b0;
      advance      = 1'b0;
      bus.sk_valid = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = ROUND;
            end
         end
         ROUND: begin
            bus.sk_valid = 1'b1;
            bus.busy     = 1'b1;
            if (bus.sk_ready) begin
               if (round_q == 4'd15) state_next = DONE;
               else                  advance    = 1'b1;
            end
         end
         DONE: begin
            bus.busy   = 1'b1;
            bus.done   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Decrypt starts from the unrotated PC-1 halves (identical to C16/D16,
   // since the schedule totals 28) and walks back with right rotations.
   assign two_step = dir_q ? !ls_one(5'd16 - {1'b0, round_q})
                           : !ls_one({1'b0, round_q} + 5'd2);
   assign cd_load  = pc1(bus.key_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         dir_q   <= 1'b0;
      end else if (load) begin
         c_q     <= bus.decrypt ? cd_load[55:28] : rotl(cd_load[55:28], 1'b0);
         d_q     <= bus.decrypt ? cd_load[27:0]  : rotl(cd_load[27:0], 1'b0);
         round_q <= '0;
         dir_q   <= bus.decrypt;
      end else if (advance) begin
         round_q <= round_q + 4'd1;
         c_q     <= dir_q ? rotr(c_q, two_step) : rotl(c_q, two_step);
         d_q     <= dir_q ? rotr(d_q, two_step) : rotl(d_q, two_step);
      end
   end

   assign bus.subkey = pc2({c_q, d_q});
   assign bus.round  = round_q;
endmodule

// File: tb/tb_des_subkey_gen.sv
// Randomised bench for des_subkey_gen against a textbook DES key-schedule model.
module tb_des_subkey_gen;
   logic clk;
   logic rst;
   des_subkey_gen_if bus();

   des_subkey_gen dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
   localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
   localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

   int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                    23,19,12,4,26,8, 16,7,27,20,13,2,
                    41,52,31,37,47,55, 30,40,51,45,33,48,
                    44,49,39,56,34,53, 46,42,50,36,29,32};
   int ls_t[$]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   logic [47:0] exp_enc[$];
   logic [47:0] got[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic des_bit(input logic [63:0] v, input int width, input int n);
      logic [63:0] t;
      t = v >> (width - n);
      return t[0];
   endfunction

   // Round n uses C0/D0 rotated left by the cumulative shift count.
   task automatic build_schedule(input logic [63:0] key);
      bit c0[$];
      bit d0[$];
      int s;
      int p;
      logic b;
      logic [47:0] sk;
      exp_enc.delete();
      for (int i = 0; i < 28; i++) begin
         c0.push_back(des_bit(key, 64, pc1_t[i]));
         d0.push_back(des_bit(key, 64, pc1_t[i + 28]));
      end
      s = 0;
      for (int r = 0; r < 16; r++) begin
         s += ls_t[r];
         sk = '0;
         for (int j = 0; j < 48; j++) begin
            p = pc2_t[j];
            b = (p <= 28) ? c0[(p - 1 + s) % 28] : d0[(p - 29 + s) % 28];
            sk = {sk[46:0], b};
         end
         exp_enc.push_back(sk);
      end
   endtask

   // Entered at a falling edge with the DUT idle; returns at the falling edge
   // one cycle after done, so consecutive calls are back-to-back.
   task automatic applyStimulus(input logic [63:0] key, input logic [63:0] model_key,
                                input logic dec, input int ready_pct, input logic poke_start);
      int idx;
      int cycles;
      logic finished;
      logic ready;
      logic [47:0] exp_sk;
      build_schedule(model_key);
      got.delete();
      bus.start    = 1'b1;
      bus.decrypt  = dec;
      bus.key_in   = key;
      bus.sk_ready = 1'b0;
      @(negedge clk);
      cycles      = 1;
      bus.start   = 1'b0;
      bus.key_in  = {$urandom, $urandom};
      bus.decrypt = ~dec;
      idx         = 0;
      finished    = 1'b0;
      while (!finished && cycles < 400) begin
         if (bus.done) begin
            checkOutput("done_count", 64'(idx), 64'd16);
            checkOutput("done_busy", 64'(bus.busy), 64'd1);
            checkOutput("done_valid", 64'(bus.sk_valid), 64'd0);
            if (ready_pct >= 100) checkOutput("done_latency", 64'(cycles), 64'd17);
            finished     = 1'b1;
            bus.start    = poke_start;
            bus.sk_ready = 1'($urandom_range(1));
         end else begin
            exp_sk = (idx < 16) ? (dec ? exp_enc[15 - idx] : exp_enc[idx]) : 48'h0;
            checkOutput("valid", 64'(bus.sk_valid), 64'd1);
            checkOutput("busy", 64'(bus.busy), 64'd1);
            checkOutput("round", 64'(bus.round), 64'(idx));
            checkOutput("subkey", 64'(bus.subkey), 64'(exp_sk));
            ready        = (int'($urandom_range(99)) < ready_pct);
            bus.sk_ready = ready;
            bus.start    = poke_start && (idx == 5);
            if (ready) begin
               got.push_back(bus.subkey);
               idx++;
            end
            @(negedge clk);
            cycles++;
         end
      end
      if (!finished) checkOutput("done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      checkOutput("idle_busy", 64'(bus.busy), 64'd0);
      checkOutput("idle_done", 64'(bus.done), 64'd0);
      bus.start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int done_seen;
      logic [63:0] rk;
      rst          = 1'b1;
      bus.start    = 1'b1;
      bus.decrypt  = 1'b0;
      bus.key_in   = KAT_KEY;
      bus.sk_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", 64'(bus.sk_valid), 64'd0);
      checkOutput("reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("reset_done", 64'(bus.done), 64'd0);
      checkOutput("reset_round", 64'(bus.round), 64'd0);
      checkOutput("reset_subkey", 64'(bus.subkey), 64'd0);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);

      applyStimulus(KAT_KEY, KAT_KEY, 1'b0, 100, 1'b0);
      checkOutput("kat_enc_first", 64'(got[0]), 64'(KAT_K1));
      checkOutput("kat_enc_last", 64'(got[15]), 64'(KAT_K16));

      applyStimulus(KAT_KEY, KAT_KEY, 1'b1, 100, 1'b1);
      checkOutput("kat_dec_first", 64'(got[0]), 64'(KAT_K16));
      checkOutput("kat_dec_last", 64'(got[15]), 64'(KAT_K1));

      applyStimulus(KAT_KEY, KAT_KEY, 1'b0, 50, 1'b1);
      checkOutput("stall_first", 64'(got[0]), 64'(KAT_K1));
      checkOutput("stall_last", 64'(got[15]), 64'(KAT_K16));

      applyStimulus(64'h123456789ABCDEF0 ^ 64'h0101010101010101, 64'h123456789ABCDEF0, 1'b0, 70, 1'b0);

      bus.start    = 1'b1;
      bus.decrypt  = 1'b0;
      bus.key_in   = KAT_KEY;
      bus.sk_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("abort_round_before", 64'(bus.round), 64'd7);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_valid", 64'(bus.sk_valid), 64'd0);
      checkOutput("abort_busy", 64'(bus.busy), 64'd0);
      checkOutput("abort_round", 64'(bus.round), 64'd0);
      checkOutput("abort_subkey", 64'(bus.subkey), 64'd0);
      rst       = 1'b0;
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      checkOutput("abort_no_done", 64'(done_seen), 64'd0);

      applyStimulus(KAT_KEY, KAT_KEY, 1'b0, 100, 1'b0);
      checkOutput("post_abort_first", 64'(got[0]), 64'(KAT_K1));
      checkOutput("post_abort_last", 64'(got[15]), 64'(KAT_K16));

      for (int t = 0; t < 6; t++) begin
         rk = {$urandom, $urandom};
         applyStimulus(rk, rk, 1'($urandom_range(1)), int'($urandom_range(100, 30)), 1'($urandom_range(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
